rtc_bcd_clock: RTL

- Parametrised BCD real-time clock: HH:MM:SS, 24-hour internal count, selectable 12-hour display.
- Adds over the previous hour/minute counter: visible seconds, configurable prescaler, run/pause, validated time-set handshake, single-cycle event pulses and an HH:MM alarm.
- Sits between the board clock and the 7-segment display multiplexer on the Basys 3 design.

---
 rtl/rtc_bcd_clock_pkg.sv | 52 +++++
 rtl/rtc_bcd_clock_counter.sv | 46 ++++
 rtl/rtc_bcd_clock.sv | 118 +++++++++++
 3 files changed

// File: rtl/rtc_bcd_clock_pkg.sv
// Shared types and helpers for the BCD real-time clock.
package rtc_pkg;

    typedef struct packed {
        logic [3:0] hh_d;
        logic [3:0] hh_u;
        logic [3:0] mm_d;
        logic [3:0] mm_u;
        logic [3:0] ss_d;
        logic [3:0] ss_u;
    } bcd_time_t;

    typedef struct packed {
        logic       pm;
        logic [3:0] hh_d;
        logic [3:0] hh_u;
    } hour12_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Two BCD digits form a legal value no larger than max.
    function automatic logic bcd_pair_le(input logic [3:0] d, input logic [3:0] u, input int max);
        return (d <= 4'd9) && (u <= 4'd9) && ((int'(d) * 10 + int'(u)) <= max);
    endfunction

    function automatic logic bcd_time_valid(input bcd_time_t t);
        return bcd_pair_le(t.hh_d, t.hh_u, HOUR_MAX) &&
               bcd_pair_le(t.mm_d, t.mm_u, MIN_MAX)  &&
               bcd_pair_le(t.ss_d, t.ss_u, SEC_MAX);
    endfunction

    // 24 h BCD hours -> 12 h display digits; 00 shows as 12 AM, 12 as 12 PM.
    function automatic hour12_t to_12h(input logic [7:0] hh);
        int      h;
        int      d12;
        hour12_t r;
        h = int'(hh[7:4]) * 10 + int'(hh[3:0]);
        if (h == 0)
            d12 = 12;
        else if (h > 12)
            d12 = h - 12;
        else
            d12 = h;
        r.pm   = (h >= 12);
        r.hh_d = (d12 >= 10) ? 4'd1 : 4'd0;
        r.hh_u = 4'(d12 % 10);
        return r;
    endfunction

endpackage

// File: rtl/rtc_bcd_clock_counter.sv
// Two-digit BCD modulo counter: counts 00..MAX, wraps to 00 with carry.
module bcd_mod_counter #(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] digits,
    output logic [7:0] nxt,
    output logic       carry
);

    localparam logic [3:0] MAX_D = 4'(MAX / 10);
    localparam logic [3:0] MAX_U = 4'(MAX % 10);

    logic at_max;

    assign at_max = (digits == {MAX_D, MAX_U});
    assign carry  = inc && at_max;

    // Next value if an increment is applied this cycle (also used for look-ahead matching).
    always_comb begin
        nxt = digits;
        if (inc) begin
            if (at_max)
                nxt = 8'h00;
            else if (digits[3:0] == 4'd9)
                nxt = {digits[7:4] + 4'd1, 4'd0};
            else
                nxt = {digits[7:4], digits[3:0] + 4'd1};
        end
    end

    // Digit register; a load overrides any increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            digits <= 8'h00;
        else if (load)
            digits <= load_val;
        else
            digits <= nxt;
    end

endmodule

// File: rtl/rtc_bcd_clock.sv
// BCD real-time clock: prescaled seconds tick, HH:MM:SS counters, validated
// load handshake, rollover pulses, HH:MM alarm and 12/24 h display mapping.
module rtc_bcd_clock
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mode_12h,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [23:0] set_time,
    output logic        set_err,
    input  logic [15:0] alarm_time,
    input  logic        alarm_en,
    output logic [3:0]  hora_d,
    output logic [3:0]  hora_u,
    output logic [3:0]  min_d,
    output logic [3:0]  min_u,
    output logic [3:0]  seg_d,
    output logic [3:0]  seg_u,
    output logic        pm,
    output logic        sec_tick,
    output logic        min_tick,
    output logic        hour_tick,
    output logic        day_tick,
    output logic        alarm_hit
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               term, xfer, set_ok, do_load, adv, alarm_ok;
    logic [7:0]         sec_q, min_q, hr_q;
    logic [7:0]         sec_nxt, min_nxt, hr_nxt;
    logic               sec_carry, min_carry, hr_carry;
    hour12_t            h12;

    assign term     = run && (presc == PRESC_LAST);
    assign xfer     = set_valid && set_ready;
    assign set_ok   = bcd_time_valid(bcd_time_t'(set_time));
    assign do_load  = xfer && set_ok;
    // A valid load swallows a coincident terminal count.
    assign adv      = term && !do_load;
    assign alarm_ok = bcd_time_valid(bcd_time_t'({alarm_time, 8'h00}));

    // Ready comes up on the first edge out of reset and stays up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            set_ready <= 1'b0;
        else
            set_ready <= 1'b1;
    end

    // Prescaler: restarts on load, wraps on terminal count, holds when paused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            presc <= '0;
        else if (do_load || term)
            presc <= '0;
        else if (run)
            presc <= presc + 1'b1;
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk(clk), .reset(reset), .inc(adv), .load(do_load),
        .load_val(set_time[7:0]), .digits(sec_q), .nxt(sec_nxt), .carry(sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk(clk), .reset(reset), .inc(sec_carry), .load(do_load),
        .load_val(set_time[15:8]), .digits(min_q), .nxt(min_nxt), .carry(min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hr (
        .clk(clk), .reset(reset), .inc(min_carry), .load(do_load),
        .load_val(set_time[23:16]), .digits(hr_q), .nxt(hr_nxt), .carry(hr_carry)
    );

    // Event pulses registered so they line up with the first cycle of the new time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            day_tick  <= 1'b0;
            alarm_hit <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sec_tick  <= adv;
            min_tick  <= sec_carry;
            hour_tick <= min_carry;
            day_tick  <= hr_carry;
            alarm_hit <= adv && alarm_en && alarm_ok && (sec_nxt == 8'h00) &&
                         ({hr_nxt, min_nxt} == alarm_time);
            set_err   <= xfer && !set_ok;
        end
    end

    // Display mapping; only the hour digits depend on mode.
    always_comb begin
        h12 = to_12h(hr_q);
        if (mode_12h) begin
            {hora_d, hora_u} = {h12.hh_d, h12.hh_u};
            pm               = h12.pm;
        end else begin
            {hora_d, hora_u} = hr_q;
            pm               = 1'b0;
        end
    end

    assign {min_d, min_u} = min_q;
    assign {seg_d, seg_u} = sec_q;

endmodule
